ball_motion_ctrl: RTL
=====================

Name: ball_motion_ctrl

Overview:
- Upstream stage of the VGA renderer. Owns the bouncing ball's position and direction state.
- Once per frame, at the frame-start strobe, it advances the ball by programmable per-axis speeds.
- It clamps the ball at the walls, so the ball never overshoots a wall.
- Its registered ball_x/ball_y feed the renderer's distance and shadow logic. It also reports bounce events and a run/pause/single-step status.

Parameters:
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- BALL_SIZE, 20, ball radius; wall margin on every edge.
- POS_W, 10, position width.
- CNT_W, 8, bounce counter width.

Ports:
- clk  in  1  pixel clock (same clock as the sync generator)
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at hpos==0 && vpos==0
- pause  in  1  level; 1 freezes motion
- step  in  1  pulse; while paused, arms exactly one update
- speed_x  in  3  pixels per frame, X axis (0 = axis frozen)
- speed_y  in  3  pixels per frame, Y axis
- load  in  1  pulse; force position
- load_x  in  POS_W  forced X
- load_y  in  POS_W  forced Y
- ball_x  out  POS_W  ball centre X
- ball_y  out  POS_W  ball centre Y
- dir_x  out  1  1 = right
- dir_y  out  1  1 = down
- bounce  out  1  one-cycle pulse on any wall hit
- corner  out  1  one-cycle pulse when both axes hit on the same update
- bounce_count  out  CNT_W  saturating count of bounce events
- paused  out  1  1 when FSM is in PAUSED or STEP_ARMED

Behaviour:
- Reset (synchronous, active-high) values:
  - ball_x=H_RES/2=320, ball_y=V_RES/2=240
  - dir_x=1, dir_y=1
  - bounce=0, corner=0, bounce_count=0
  - FSM=RUN, paused=0
- Latency: all outputs are registered. An update triggered at cycle N is visible at cycle N+1.
- bounce and corner are 0 in every cycle without an update.
- FSM states:
  - RUN: a frame_tick performs an update. pause=1 goes to PAUSED.
  - PAUSED: frame_tick is ignored. step goes to STEP_ARMED. pause=0 goes to RUN.
  - STEP_ARMED: the next frame_tick performs one update, then goes to PAUSED. Extra step pulses collapse into one. pause=0 goes to RUN; the armed step is absorbed into normal running.
- pause=1 in the same cycle as frame_tick while in RUN: pause wins and no update occurs.
- Per-axis update, computed in POS_W+1 bits, with s = speed, lo = BALL_SIZE, hi = RES-BALL_SIZE:
  - Moving forward: n = pos+s. If n >= hi, then pos=hi, dir=0 and the axis hits; otherwise pos=n.
  - Moving backward: n = pos-s. If n <= lo (including underflow), then pos=lo, dir=1 and the axis hits; otherwise pos=n.
  - s==0: position and direction hold, no hit. This holds even when the ball sits on a wall.
- Speeds are sampled in the update cycle only.
- Event outputs after an update:
  - bounce = hit_x | hit_y; corner = hit_x & hit_y.
  - bounce_count increments by exactly 1 per update with bounce=1; a corner counts once.
  - bounce_count saturates at 2^CNT_W-1.
- load:
  - Next cycle, ball_x=clamp(load_x, BALL_SIZE, H_RES-BALL_SIZE) and ball_y likewise against V_RES.
  - Directions, counter and FSM state are unchanged, and no bounce is flagged.
  - load wins over a simultaneous frame_tick; that update is dropped. If the FSM is in STEP_ARMED, the step stays armed.
- reset wins over everything, including load and frame_tick in the same cycle.
- A reset mid-operation restores the reset values on the next edge, and any armed step is discarded.

Decomposition:
- sleepwell_pkg holds:
  - H_RES, V_RES, BALL_SIZE
  - the motion FSM enum: RUN, PAUSED, STEP_ARMED
  - the speed width (3)
- Sub-module axis_stepper is instantiated twice, once for X and once for Y.
  - Purely combinational: pos, dir, speed, lo, hi -> next_pos, next_dir, hit.
  - The parent owns all registers, the FSM, the counter and load muxing.

Test Plan:
- Reset, then one frame_tick with speeds 2/2 -> the cycle after the tick shows ball=(322,242), dirs 1/1, bounce=0, count=0.
- load (617,100), dirs 1/1, speeds 5/0, frame_tick -> ball_x=620 (clamped, not 622), dir_x=0, ball_y=100, bounce=1, corner=0, count=1.
- load (618,458), speeds 2/2, frame_tick -> ball=(620,460), dir_x=0, dir_y=0, bounce=1, corner=1, count=1.
- pause=1 with 3 frame_ticks -> position unchanged and paused=1. Then 2 step pulses followed by 2 frame_ticks -> exactly one +2/+2 advance, and the FSM is back in PAUSED.
- pause=1 and frame_tick in the same cycle while in RUN -> no update. load and frame_tick in the same cycle -> the loaded value appears unmodified.
- Force 260 bounces using load/tick pairs -> bounce_count stops at 255. Then assert reset together with frame_tick -> (320,240), count=0, FSM=RUN.

Source files
------------

// File: rtl/sleepwell_pkg.sv
// Shared constants and types for the ball motion path.
// Screen geometry, speed width and the motion FSM states.
package sleepwell_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int BALL_SIZE = 20;
  localparam int SPD_W     = 3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    PAUSED     = 2'd1,
    STEP_ARMED = 2'd2
  } motion_state_e;

endpackage

// File: rtl/axis_stepper.sv
// One-axis wall-clamped position step, purely combinational.
// A zero speed holds position and direction, even on a wall.
module axis_stepper
  import sleepwell_pkg::*;
#(
  parameter int POS_W = 10
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  input  logic [SPD_W-1:0] speed,
  input  logic [POS_W-1:0] lo,
  input  logic [POS_W-1:0] hi,
  output logic [POS_W-1:0] next_pos,
  output logic             next_dir,
  output logic             hit
);

  logic [POS_W:0] fwd;
  logic [POS_W:0] bwd;

  // Extra MSB catches underflow when stepping back past zero.
  always_comb begin
    fwd      = {1'b0, pos} + (POS_W+1)'(speed);
    bwd      = {1'b0, pos} - (POS_W+1)'(speed);
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (speed != '0) begin
      if (dir) begin
        if (fwd >= {1'b0, hi}) begin
          next_pos = hi;
          next_dir = 1'b0;
          hit      = 1'b1;
        end else begin
          next_pos = fwd[POS_W-1:0];
        end
      end else begin
        if (bwd[POS_W] || (bwd <= {1'b0, lo})) begin
          next_pos = lo;
          next_dir = 1'b1;
          hit      = 1'b1;
        end else begin
          next_pos = bwd[POS_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position/direction owner with run/pause/step.
// Registers, FSM, bounce counter and load muxing live here.
module ball_motion_ctrl
  import sleepwell_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             step,
  input  logic [SPD_W-1:0] speed_x,
  input  logic [SPD_W-1:0] speed_y,
  input  logic             load,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             bounce,
  output logic             corner,
  output logic [CNT_W-1:0] bounce_count,
  output logic             paused
);

  localparam logic [POS_W-1:0] X_LO  = POS_W'(BALL_SIZE);
  localparam logic [POS_W-1:0] X_HI  = POS_W'(H_RES - BALL_SIZE);
  localparam logic [POS_W-1:0] Y_LO  = POS_W'(BALL_SIZE);
  localparam logic [POS_W-1:0] Y_HI  = POS_W'(V_RES - BALL_SIZE);
  localparam logic [POS_W-1:0] X_MID = POS_W'(H_RES / 2);
  localparam logic [POS_W-1:0] Y_MID = POS_W'(V_RES / 2);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  function automatic logic [POS_W-1:0] clamp(
    input logic [POS_W-1:0] v,
    input logic [POS_W-1:0] lo,
    input logic [POS_W-1:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  motion_state_e state_q, state_d;
  logic [POS_W-1:0] ball_x_q, ball_x_d;
  logic [POS_W-1:0] ball_y_q, ball_y_d;
  logic dir_x_q, dir_x_d;
  logic dir_y_q, dir_y_d;
  logic bounce_q, bounce_d;
  logic corner_q, corner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic upd;
  logic [POS_W-1:0] nx, ny;
  logic ndx, ndy, hit_x, hit_y;

  axis_stepper #(.POS_W(POS_W)) u_x (
    .pos(ball_x_q), .dir(dir_x_q), .speed(speed_x),
    .lo(X_LO), .hi(X_HI),
    .next_pos(nx), .next_dir(ndx), .hit(hit_x)
  );

  axis_stepper #(.POS_W(POS_W)) u_y (
    .pos(ball_y_q), .dir(dir_y_q), .speed(speed_y),
    .lo(Y_LO), .hi(Y_HI),
    .next_pos(ny), .next_dir(ndy), .hit(hit_y)
  );

  // State register; reset discards any armed step.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state; a load-blocked tick keeps the step armed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: if (pause) state_d = PAUSED;
      PAUSED: begin
        if (!pause)    state_d = RUN;
        else if (step) state_d = STEP_ARMED;
      end
      STEP_ARMED: begin
        if (!pause)                   state_d = RUN;
        else if (frame_tick && !load) state_d = PAUSED;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: update enable and pause status.
  always_comb begin
    upd    = 1'b0;
    paused = (state_q != RUN);
    unique case (state_q)
      RUN:        upd = frame_tick & ~pause & ~load;
      STEP_ARMED: upd = frame_tick & ~load;
      default:    upd = 1'b0;
    endcase
  end

  // Datapath next values: load beats update, events only on update.
  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = 1'b0;
    corner_d = 1'b0;
    cnt_d    = cnt_q;
    if (load) begin
      ball_x_d = clamp(load_x, X_LO, X_HI);
      ball_y_d = clamp(load_y, Y_LO, Y_HI);
    end else if (upd) begin
      ball_x_d = nx;
      ball_y_d = ny;
      dir_x_d  = ndx;
      dir_y_d  = ndy;
      bounce_d = hit_x | hit_y;
      corner_d = hit_x & hit_y;
      if ((hit_x | hit_y) && (cnt_q != CMAX))
        cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x_q <= X_MID;
      ball_y_q <= Y_MID;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      bounce_q <= bounce_d;
      corner_q <= corner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign dir_x        = dir_x_q;
  assign dir_y        = dir_y_q;
  assign bounce       = bounce_q;
  assign corner       = corner_q;
  assign bounce_count = cnt_q;

endmodule
